// File: rtl/sort_sequencer.sv
// Insertion-sort controller: holds up to N characters and orders them ascending,
// using an MSB-first bit-serial comparator for every decision.
module sort_sequencer #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Wr,
  input  logic [W-1:0]  Din,
  input  logic          St,
  input  logic          Clr,
  input  logic [AW-1:0] RdAddr,
  output logic [W-1:0]  Dout,
  output logic [CW-1:0] Cnt,
  output logic          Busy,
  output logic          Done,
  output logic          Swp
);
  localparam int NS = 1 << AW;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   i_q, i_d, j_q, j_d, jm1_s;
  logic [W-1:0]    xc_q, xc_d, yc_q, yc_d;
  logic            gt_q, gt_d, lt_q, lt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [W-1:0]    a_q [NS];
  logic [W-1:0]    a_d [NS];
  logic            busy_q, busy_d, done_q, done_d, swp_q, swp_d;
  logic            adv_s;

  assign jm1_s = j_q - AW'(1);

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    bit_d   = bit_q;
    a_d     = a_q;
    adv_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Clr) begin
          cnt_d = '0;
        end else if (Wr) begin
          if (cnt_q < CW'(N)) begin
            a_d[cnt_q[AW-1:0]] = Din;
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else if (St) begin
          if (cnt_q >= CW'(2)) begin
            i_d     = AW'(1);
            j_d     = AW'(1);
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        xc_d    = a_q[jm1_s];
        yc_d    = a_q[j_q];
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // The first differing bit, seen MSB first, decides the ordering.
        if (!gt_q && !lt_q) begin
          gt_d = xc_q[W-1] & ~yc_q[W-1];
          lt_d = ~xc_q[W-1] & yc_q[W-1];
        end else begin
          gt_d = gt_q;
          lt_d = lt_q;
        end
        xc_d = xc_q << 1;
        yc_d = yc_q << 1;
        if (bit_q == BW'(W - 1)) begin
          state_d = DECIDE;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      DECIDE: begin
        if (gt_q) begin
          a_d[jm1_s] = a_q[j_q];
          a_d[j_q]   = a_q[jm1_s];
          if (j_q > AW'(1)) begin
            j_d     = jm1_s;
            state_d = LOAD;
          end else begin
            adv_s = 1'b1;
          end
        end else begin
          adv_s = 1'b1;
        end
        if (adv_s) begin
          if (CW'(i_q) + CW'(1) == cnt_q) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + AW'(1);
            j_d     = i_q + AW'(1);
            state_d = LOAD;
          end
        end else begin
          i_d = i_q;
        end
      end
      DONE: begin
        if (Clr) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == SHIFT) || (state_d == DECIDE);
    // A start with fewer than two characters shows Done one cycle after entering DONE.
    done_d = (state_d == DONE) && (state_q != IDLE);
    swp_d  = (state_d == DECIDE) && gt_d;
  end

  // State, array and registered status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      swp_q   <= 1'b0;
      for (int k = 0; k < NS; k++) a_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      swp_q   <= swp_d;
      for (int k = 0; k < NS; k++) a_q[k] <= a_d[k];
    end
  end

  assign Dout = a_q[RdAddr];
  assign Cnt  = cnt_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Swp  = swp_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: an abstract insertion-sort model predicts every output
// each cycle, and directed runs pin cycle counts, swap counts and final arrays.
module tb_sort_sequencer;
  localparam int N = 8;
  localparam int W = 8;
  localparam int CL = W + 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Wr = 1'b0, St = 1'b0, Clr = 1'b0;
  logic [7:0] Din = 8'h00;
  logic [2:0] RdAddr = 3'd0;
  logic [7:0] Dout;
  logic [3:0] Cnt;
  logic       Busy, Done, Swp;

  sort_sequencer #(.N(N), .W(W)) dut (
    .CLK(CLK), .RST(RST), .Wr(Wr), .Din(Din), .St(St), .Clr(Clr),
    .RdAddr(RdAddr), .Dout(Dout), .Cnt(Cnt), .Busy(Busy), .Done(Done), .Swp(Swp)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Abstract model: array contents, count, and a precomputed list of compares.
  typedef enum {M_IDLE, M_SORT, M_PEND, M_DONE} mph_t;
  mph_t       m_ph = M_IDLE;
  int         m_cnt = 0;
  logic [7:0] m_arr [8];
  int         m_t = 0;
  int         m_ncmp = 0;
  bit         m_sw [64];
  int         m_j [64];
  logic [7:0] m_tmp;
  int         m_k;

  task automatic plan();
    logic [7:0] tmp [8];
    int j;
    tmp = m_arr;
    m_ncmp = 0;
    for (int i = 1; i < m_cnt; i++) begin
      j = i;
      while (j > 0) begin
        m_j[m_ncmp] = j;
        if (tmp[j-1] > tmp[j]) begin
          logic [7:0] t;
          t = tmp[j-1]; tmp[j-1] = tmp[j]; tmp[j] = t;
          m_sw[m_ncmp] = 1'b1;
          m_ncmp++;
          j--;
        end else begin
          m_sw[m_ncmp] = 1'b0;
          m_ncmp++;
          j = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      m_ph = M_IDLE; m_cnt = 0; m_t = 0;
      for (int k = 0; k < 8; k++) m_arr[k] = 8'h00;
    end else begin
      case (m_ph)
        M_IDLE: begin
          if (Clr) m_cnt = 0;
          else if (Wr) begin
            if (m_cnt < N) begin m_arr[m_cnt] = Din; m_cnt++; end
          end else if (St) begin
            if (m_cnt >= 2) begin plan(); m_ph = M_SORT; m_t = 0; end
            else m_ph = M_PEND;
          end
        end
        M_SORT: begin
          if ((m_t % CL) == CL - 1 && m_sw[m_t / CL]) begin
            m_k = m_j[m_t / CL];
            m_tmp = m_arr[m_k-1]; m_arr[m_k-1] = m_arr[m_k]; m_arr[m_k] = m_tmp;
          end
          m_t++;
          if (m_t == m_ncmp * CL) m_ph = M_DONE;
        end
        default: begin
          if (Clr) begin m_cnt = 0; m_ph = M_IDLE; end
          else m_ph = M_DONE;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("cnt", Cnt, m_cnt);
    chk("busy", Busy, m_ph == M_SORT);
    chk("done", Done, m_ph == M_DONE);
    chk("swp", Swp, m_ph == M_SORT && (m_t % CL) == CL - 1 && m_sw[m_t / CL]);
    chk("dout", Dout, m_arr[RdAddr]);
  end

  task automatic wr(input logic [7:0] d);
    Wr = 1'b1; Din = d;
    @(posedge CLK); #1;
    Wr = 1'b0;
  endtask

  task automatic clr();
    Clr = 1'b1;
    @(posedge CLK); #1;
    Clr = 1'b0;
  endtask

  task automatic rd(input string nm, input int addr, input logic [7:0] exp);
    RdAddr = addr[2:0];
    @(negedge CLK);
    chk(nm, Dout, exp);
  endtask

  // Pulse St, then count cycles until Done and Swp pulses seen; optionally poke St/Clr mid-sort.
  task automatic sort_run(input int inject, output int cyc, output int nsw);
    St = 1'b1;
    @(posedge CLK); #1;
    St = 1'b0;
    cyc = 0; nsw = 0;
    while (cyc < 400) begin
      @(negedge CLK);
      St = 1'b0; Clr = 1'b0;
      if (Done) break;
      if (Swp) nsw++;
      if (cyc == inject) begin St = 1'b1; Clr = 1'b1; end
      @(posedge CLK);
      cyc++;
    end
  endtask

  int c, s;

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 0; k < 8; k++) rd("rst_dout", k, 8'h00);
    chk("rst_cnt", Cnt, 0);

    wr(8'h44); wr(8'h43); wr(8'h42); wr(8'h41);
    sort_run(-1, c, s);
    chk("dcba_cycles", c, 60);
    chk("dcba_swaps", s, 6);
    for (int k = 0; k < 4; k++) rd("dcba_arr", k, 8'h41 + 8'(k));
    clr();
    @(negedge CLK); chk("clr_cnt", Cnt, 0);

    for (int k = 0; k < 8; k++) wr(8'h41 + 8'(k));
    wr(8'h5A);
    @(negedge CLK); chk("full_cnt", Cnt, 8);
    sort_run(-1, c, s);
    chk("abc_cycles", c, 70);
    chk("abc_swaps", s, 0);
    for (int k = 0; k < 8; k++) rd("abc_arr", k, 8'h41 + 8'(k));
    clr();

    wr(8'h42); wr(8'h41);
    Wr = 1'b1; St = 1'b1; Din = 8'h42;
    @(posedge CLK); #1;
    Wr = 1'b0; St = 1'b0;
    @(negedge CLK);
    chk("wrst_cnt", Cnt, 3);
    chk("wrst_busy", Busy, 0);
    sort_run(5, c, s);
    chk("bab_cycles", c, 20);
    chk("bab_swaps", s, 1);
    rd("bab_arr0", 0, 8'h41); rd("bab_arr1", 1, 8'h42); rd("bab_arr2", 2, 8'h42);
    clr();
    @(negedge CLK); chk("bab_clr_cnt", Cnt, 0);

    wr(8'h7A);
    sort_run(-1, c, s);
    chk("one_cycles", c, 1);
    chk("one_swaps", s, 0);
    clr();

    for (int k = 0; k < 8; k++) wr(8'h48 - 8'(k));
    RdAddr = 3'd3;
    St = 1'b1;
    @(posedge CLK); #1;
    St = 1'b0;
    repeat (49) @(posedge CLK);
    #1 chk("mid_busy", Busy, 1);
    RST = 1'b1;
    #1;
    chk("mid_rst_cnt", Cnt, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_dout", Dout, 8'h00);
    @(posedge CLK); #1 RST = 1'b0;

    for (int k = 0; k < 8; k++) wr(8'h48 - 8'(k));
    sort_run(-1, c, s);
    chk("rev_cycles", c, 280);
    chk("rev_swaps", s, 28);
    for (int k = 0; k < 8; k++) rd("rev_arr", k, 8'h41 + 8'(k));

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Insertion-sort controller for the ASCII character sorter. It holds up to N characters in a local register array and runs insertion sort over them, making every ordering decision with an internal MSB-first bit-serial comparator. It sequences loading, compare, swap and index update, then presents the sorted array for readout. It sits between the character input stage and the display/output stage.

## Interface
- N, 8, maximum number of characters stored (2..16)
- W, 8, character width in bits
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- Wr  in  1  write Din into the next free slot (IDLE only)
- Din  in  W  character to load
- St  in  1  start sort (IDLE only)
- Clr  in  1  empty the array and return to IDLE (IDLE or DONE only)
- RdAddr  in  clog2(N)  readout index
- Dout  out  W  combinational A[RdAddr]
- Cnt  out  clog2(N+1)  number of characters loaded
- Busy  out  1  high in LOAD, SHIFT and DECIDE
- Done  out  1  high in DONE
- Swp  out  1  one-cycle pulse in each DECIDE cycle that performs a swap

## Operation
- States: IDLE, LOAD, SHIFT, DECIDE, DONE.
- Reset:
  - state=IDLE; Cnt=0; all A[k]=0; i=j=0; shift registers and compare flags cleared.
  - Busy=Done=Swp=0; Dout=0.
- IDLE:
  - Wr with Cnt<N: A[Cnt]<=Din, Cnt++. Wr with Cnt==N is ignored.
  - St and Wr in the same cycle: Wr executes and St is ignored.
  - St with Cnt>=2: i<=1, j<=1, go to LOAD.
  - St with Cnt<2: go directly to DONE.
- LOAD (1 cycle):
  - XC<=A[j-1], YC<=A[j]; clear gt and lt; bit counter <=0; go to SHIFT.
- SHIFT (W cycles):
  - Each cycle, compare x=XC[W-1] against y=YC[W-1].
  - If neither gt nor lt is set yet: x&~y sets gt; ~x&y sets lt.
  - Shift XC and YC left by 1.
  - After the W-th shift cycle, go to DECIDE.
- DECIDE (1 cycle):
  - If gt: swap A[j-1] and A[j], pulse Swp.
    - If j>1: j--, go to LOAD.
    - Otherwise advance i.
  - If not gt (less or equal): advance i. Equal characters are never swapped, so the sort is stable.
  - Advance i: if i+1==Cnt, go to DONE; otherwise i<=i+1, j<=i+1, go to LOAD.
- DONE: hold the array. Clr goes to IDLE with Cnt<=0; array contents are kept but no longer valid. St and Wr are ignored.
- Clr in IDLE resets Cnt to 0. Clr beats Wr and St in the same cycle. Clr, St and Wr are ignored while Busy.
- Dout is always A[RdAddr]; it reflects swaps in the cycle after DECIDE. RdAddr>=Cnt returns the stale slot value.
- RST asserted mid-sort: immediate return to reset values, and the partially sorted array is lost.

## Timing
- One compare = LOAD + W SHIFT + DECIDE = W+2 cycles (10 at W=8).
- C = total compares = Σ over i of (swaps at i + 1 if the insertion stopped with j>0 on a not-greater result).
- St sampled at edge E with Cnt>=2: Busy=1 from E through E+C(W+2)−1; Done=1 from edge E+C(W+2).
- St sampled at edge E with Cnt<2: Done=1 from edge E+1, and Busy never rises.
- Swp is high exactly during DECIDE cycles that swap. It is never high in any other state.
- The array only changes on Wr in IDLE and on the swap edge at the end of DECIDE.

## Test plan
- Reset then idle: Cnt=0, Busy=Done=Swp=0, Dout=0 for every RdAddr.
- Load 0x44,0x43,0x42,0x41 and pulse St -> 6 Swp pulses; Done at E+60; A[0..3]=0x41,0x42,0x43,0x44.
- Load 8 already-sorted characters "ABCDEFGH" -> 7 compares, no Swp pulses, Done at E+70, array unchanged.
- Load "BAB" (0x42,0x41,0x42) -> 1 Swp pulse, Done at E+20, result 0x41,0x42,0x42. Then Clr -> IDLE with Cnt=0.
- Edge cases:
  - 9 writes with N=8: the 9th is ignored and Cnt=8.
  - Wr and St in the same cycle: only the write occurs.
  - Cnt=1 and St: Done at E+1.
  - St or Clr pulsed while Busy: no effect.
- Load "HGFEDCBA" (8 characters), St, then assert RST at E+50 -> all outputs and Cnt return to reset values immediately. Reload and resort -> 28 swaps, Done at E+280.
